prng_stream_reader: RTL

PRNG_STREAM_READER -- requirements
Module: prng_stream_reader

---
 rtl/prng_pkg.sv | 15 +
 rtl/sync_fifo.sv | 58 +++++
 rtl/prng_stream_reader.sv | 126 ++++++++++++
 3 files changed

// File: rtl/prng_pkg.sv
// Shared types and constants for the PRNG stream reader and its PRNG pairing.
package prng_pkg;

  localparam int unsigned WordW = 64;

  localparam logic [WordW-1:0] DefaultSeed1 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [WordW-1:0] DefaultSeed2 = 64'hCAFE_BABE_DEAD_BEEF;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } req_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; storage is left unreset on purpose.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_level == LW'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/prng_stream_reader.sv
// Requests 64-bit words from a PRNG, buffers them and streams them out as
// LSB-first slices, flagging repeated words and unanswered requests.
module prng_stream_reader
  import prng_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned OUT_W   = 16,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   next,
  input  logic [WordW-1:0]       rand_in,
  input  logic                   rand_valid,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   err_clr,
  output logic                   rep_err,
  output logic                   tmo_err,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned LvlW   = $clog2(DEPTH) + 1;
  localparam int unsigned NSlice = WordW / OUT_W;
  localparam int unsigned IdxW   = (NSlice > 1) ? $clog2(NSlice) : 1;

  req_state_e                     r_state;
  logic                           r_next;
  logic [7:0]                     r_cnt;
  logic [WordW-1:0]               r_prev;
  logic                           r_rep_err;
  logic                           r_tmo_err;
  logic [IdxW-1:0]                r_idx;

  logic                           w_push;
  logic                           w_pop;
  logic                           w_xfer;
  logic                           w_last;
  logic                           w_tmo;
  logic                           w_rep;
  logic                           w_full;
  logic                           w_empty;
  logic [WordW-1:0]               w_head;
  logic [LvlW-1:0]                w_level;
  logic [NSlice-1:0][OUT_W-1:0]   w_slices;

  sync_fifo #(
    .WIDTH (WordW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (rand_in),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // Only a response to the single outstanding request is ever accepted.
  assign w_push = (r_state == StWait) && rand_valid;
  assign w_tmo  = (r_state == StWait) && !rand_valid && (r_cnt == 8'(TIMEOUT - 1));
  assign w_rep  = w_push && (rand_in == r_prev);

  assign w_xfer = out_valid && out_ready;
  assign w_last = (r_idx == IdxW'(NSlice - 1));
  assign w_pop  = w_xfer && w_last;

  assign w_slices  = w_head;
  assign out_data  = w_slices[r_idx];
  assign out_valid = !w_empty;
  assign level     = w_level;
  assign next      = r_next;
  assign rep_err   = r_rep_err;
  assign tmo_err   = r_tmo_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_next  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_next <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (!w_full) begin
            r_state <= StReq;
            r_next  <= 1'b1;
          end
        end
        StReq: begin
          r_state <= StWait;
          r_cnt   <= '0;
        end
        StWait: begin
          if (w_push || w_tmo) begin
            r_state <= StIdle;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // A fresh error event wins over a clear in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev    <= '0;
      r_rep_err <= 1'b0;
      r_tmo_err <= 1'b0;
      r_idx     <= '0;
    end else begin
      if (w_push) r_prev <= rand_in;
      r_rep_err <= w_rep | (r_rep_err & ~err_clr);
      r_tmo_err <= w_tmo | (r_tmo_err & ~err_clr);
      if (w_xfer) r_idx <= w_last ? '0 : r_idx + IdxW'(1);
    end
  end

endmodule
